// File: rtl/w_load_unit.sv
// Load-data unit: alignment check, single aligned bus read with timeout,
// lane extraction and zero/sign extension of the returned beat.
module w_load_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  output logic              bus_rd_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rd_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_exc,
  output logic [4:0]        rsp_exccode,
  output logic              busy
);

  localparam int OFFW = $clog2(DATA_W / 8);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_BU = 3'b001;
  localparam logic [2:0] OP_B  = 3'b010;
  localparam logic [2:0] OP_HU = 3'b011;
  localparam logic [2:0] OP_H  = 3'b100;
  localparam logic [2:0] OP_WU = 3'b101;
  localparam logic [2:0] OP_D  = 3'b110;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  logic [1:0]        r_state;
  logic [OFFW-1:0]   r_off;
  logic [2:0]        r_op;
  logic [CNTW-1:0]   r_cnt;

  logic [2:0]        w_op_in;
  logic [OFFW-1:0]   w_off_in;
  logic              w_misal;
  logic [DATA_W-1:0] w_bsh;
  logic [DATA_W-1:0] w_hsh;
  logic [DATA_W-1:0] w_wsh;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_ext;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUS) || (r_state == S_RESP);

  // Reserved/unsupported encodings collapse onto the sign-extended word load.
  always_comb begin
    w_op_in  = req_op;
    if (req_op == 3'b111 || (req_op == OP_D && DATA_W != 64))
      w_op_in = OP_W;
    w_off_in = req_addr[OFFW-1:0];
    case (w_op_in)
      OP_BU, OP_B: w_misal = 1'b0;
      OP_HU, OP_H: w_misal = w_off_in[0];
      OP_D:        w_misal = |w_off_in;
      default:     w_misal = |w_off_in[1:0];
    endcase
  end

  always_comb begin
    w_bsh  = bus_rdata >> {r_off, 3'b000};
    w_hsh  = bus_rdata >> {r_off[OFFW-1:1], 4'b0000};
    w_wsh  = bus_rdata >> {(r_off >> 2), 5'b00000};
    w_byte = w_bsh[7:0];
    w_half = w_hsh[15:0];
    w_word = w_wsh[31:0];
    w_ext  = '0;
    case (r_op)
      OP_B, OP_BU: begin
        w_ext      = {DATA_W{(r_op == OP_B) & w_byte[7]}};
        w_ext[7:0] = w_byte;
      end
      OP_H, OP_HU: begin
        w_ext       = {DATA_W{(r_op == OP_H) & w_half[15]}};
        w_ext[15:0] = w_half;
      end
      OP_D: w_ext = bus_rdata;
      default: begin
        w_ext       = {DATA_W{(r_op == OP_W) & w_word[31]}};
        w_ext[31:0] = w_word;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      bus_rd_req  <= 1'b0;
      bus_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_exc     <= 1'b0;
      rsp_exccode <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_off    <= w_off_in;
            r_op     <= w_op_in;
            r_cnt    <= '0;
            bus_addr <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            if (w_misal) begin
              r_state     <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_data    <= '0;
              rsp_exc     <= 1'b1;
              rsp_exccode <= EXC_ADEL;
            end else begin
              r_state    <= S_BUS;
              bus_rd_req <= 1'b1;
            end
          end
        end
        S_BUS: begin
          // An ack on the final count still wins over the timeout.
          if (bus_rd_ack) begin
            r_state     <= S_RESP;
            bus_rd_req  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= w_ext;
            rsp_exc     <= 1'b0;
            rsp_exccode <= '0;
          end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
            r_state     <= S_RESP;
            bus_rd_req  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_exc     <= 1'b1;
            rsp_exccode <= EXC_DBE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w_load_unit.sv
// Scoreboard bench for w_load_unit: a 32-bit instance (TIMEOUT 16) and a
// 64-bit instance (TIMEOUT 4) share one stimulus driver selected by sel.
module tb_w_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        c_req_valid;
  logic [31:0] c_req_addr;
  logic [2:0]  c_req_op;
  logic        c_ack;
  logic [63:0] c_rdata;

  logic        a_req_ready, a_bus_rd_req, a_rsp_valid, a_rsp_exc, a_busy;
  logic [31:0] a_bus_addr, a_rsp_data;
  logic [4:0]  a_rsp_exccode;
  logic        b_req_ready, b_bus_rd_req, b_rsp_valid, b_rsp_exc, b_busy;
  logic [31:0] b_bus_addr;
  logic [63:0] b_rsp_data;
  logic [4:0]  b_rsp_exccode;

  logic        m_req_ready, m_bus_rd_req, m_rsp_valid, m_busy;
  logic [31:0] m_bus_addr;

  assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign m_bus_rd_req = sel ? b_bus_rd_req : a_bus_rd_req;
  assign m_rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_bus_addr   = sel ? b_bus_addr   : a_bus_addr;

  w_load_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) u_d32 (
    .clk(clk), .reset(reset),
    .req_valid(c_req_valid & ~sel), .req_ready(a_req_ready),
    .req_addr(c_req_addr), .req_op(c_req_op),
    .bus_rd_req(a_bus_rd_req), .bus_addr(a_bus_addr),
    .bus_rd_ack(c_ack & ~sel), .bus_rdata(c_rdata[31:0]),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .rsp_exc(a_rsp_exc), .rsp_exccode(a_rsp_exccode), .busy(a_busy)
  );

  w_load_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_d64 (
    .clk(clk), .reset(reset),
    .req_valid(c_req_valid & sel), .req_ready(b_req_ready),
    .req_addr(c_req_addr), .req_op(c_req_op),
    .bus_rd_req(b_bus_rd_req), .bus_addr(b_bus_addr),
    .bus_rd_ack(c_ack & sel), .bus_rdata(c_rdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .rsp_exc(b_rsp_exc), .rsp_exccode(b_rsp_exccode), .busy(b_busy)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [4:0]  c;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_rsp_valid === 1'b1) begin
      if (q32.size() == 0) chk("d32 unexpected rsp_valid", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("d32 rsp_data", 64'(a_rsp_data), e.d);
        chk("d32 rsp_exc", 64'(a_rsp_exc), 64'(e.e));
        chk("d32 rsp_exccode", 64'(a_rsp_exccode), 64'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rsp_valid === 1'b1) begin
      if (q64.size() == 0) chk("d64 unexpected rsp_valid", 64'd1, 64'd0);
      else begin
        e = q64.pop_front();
        chk("d64 rsp_data", b_rsp_data, e.d);
        chk("d64 rsp_exc", 64'(b_rsp_exc), 64'(e.e));
        chk("d64 rsp_exccode", 64'(b_rsp_exccode), 64'(e.c));
      end
    end
  end

  // One load; cycle 0 is the accept cycle, responses land at the monitor.
  task automatic do_load(input logic s, input logic [31:0] a, input logic [2:0] op,
                         input int ack_at, input logic [63:0] rd,
                         input logic [63:0] ed, input logic ee, input logic [4:0] ec);
    int   to, rc, last;
    logic mis;
    exp_t e;
    to   = s ? 4 : 16;
    mis  = (ec == 5'd4);
    rc   = mis ? 1 : ((ack_at > 0) ? ack_at + 1 : to + 1);
    last = mis ? 0 : ((ack_at > 0) ? ack_at : to);
    @(negedge clk);
    sel = s;
    #1;
    chk("req_ready before accept", 64'(m_req_ready), 64'd1);
    c_req_valid = 1'b1;
    c_req_addr  = a;
    c_req_op    = op;
    e.d = ed; e.e = ee; e.c = ec;
    if (s) q64.push_back(e); else q32.push_back(e);
    for (int c = 1; c <= rc + 1; c++) begin
      @(negedge clk);
      c_req_valid = 1'b0;
      c_req_addr  = ~a;
      c_req_op    = ~op;
      c_ack       = (c == ack_at);
      c_rdata     = (c == ack_at) ? rd : ~rd;
      chk("bus_rd_req", 64'(m_bus_rd_req), 64'(c <= last));
      if (c <= last)
        chk("bus_addr", 64'(m_bus_addr), 64'(a & (s ? ~32'h7 : ~32'h3)));
      chk("rsp_valid timing", 64'(m_rsp_valid), 64'(c == rc));
      chk("busy", 64'(m_busy), 64'(c <= rc));
      if (c == rc + 1) chk("req_ready after resp", 64'(m_req_ready), 64'd1);
    end
    c_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    c_req_valid = 1'b0; c_req_addr = '0; c_req_op = '0; c_ack = 1'b0; c_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset d32 req_ready", 64'(a_req_ready), 64'd1);
    chk("reset d32 outputs", {a_bus_rd_req, a_bus_addr, a_rsp_valid, a_rsp_exc, a_rsp_exccode, a_busy}, 64'd0);
    chk("reset d32 rsp_data", 64'(a_rsp_data), 64'd0);
    chk("reset d64 req_ready", 64'(b_req_ready), 64'd1);
    chk("reset d64 outputs", {b_bus_rd_req, b_bus_addr, b_rsp_valid, b_rsp_exc, b_rsp_exccode, b_busy}, 64'd0);
    chk("reset d64 rsp_data", b_rsp_data, 64'd0);
    reset = 1'b0;

    // Stray ack while idle must be ignored.
    @(negedge clk); c_ack = 1'b1; c_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); c_ack = 1'b0;
    chk("stray ack rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("stray ack req_ready", 64'(a_req_ready), 64'd1);

    do_load(1'b0, 32'h1003, 3'b010, 1, 64'h8000_0000_80FF_1234, 64'hFFFF_FF80, 1'b0, 5'd0);
    do_load(1'b0, 32'h2002, 3'b011, 5, 64'h80017FFF, 64'h0000_8001, 1'b0, 5'd0);
    do_load(1'b0, 32'h0001, 3'b100, 0, 64'h0, 64'h0, 1'b1, 5'd4);
    do_load(1'b0, 32'h1001, 3'b001, 2, 64'h80FF1234, 64'h12, 1'b0, 5'd0);
    do_load(1'b0, 32'h1002, 3'b010, 1, 64'h80FF1234, 64'hFFFF_FFFF, 1'b0, 5'd0);
    do_load(1'b0, 32'h2000, 3'b100, 1, 64'h80017FFF, 64'h7FFF, 1'b0, 5'd0);
    do_load(1'b0, 32'h0004, 3'b110, 3, 64'h8000_0000, 64'h8000_0000, 1'b0, 5'd0);
    do_load(1'b0, 32'h0006, 3'b111, 0, 64'h0, 64'h0, 1'b1, 5'd4);
    do_load(1'b0, 32'h0003, 3'b011, 0, 64'h0, 64'h0, 1'b1, 5'd4);
    do_load(1'b0, 32'h0010, 3'b101, 2, 64'hCAFEF00D, 64'hCAFE_F00D, 1'b0, 5'd0);
    do_load(1'b0, 32'h0040, 3'b000, 0, 64'h0, 64'h0, 1'b1, 5'd7);

    do_load(1'b1, 32'h0100, 3'b000, 0, 64'h0, 64'h0, 1'b1, 5'd7);
    do_load(1'b1, 32'h0100, 3'b000, 4, 64'h1111_2222_8000_0003, 64'hFFFF_FFFF_8000_0003, 1'b0, 5'd0);
    do_load(1'b1, 32'h000C, 3'b101, 1, 64'h8765_4321_0000_0001, 64'h0000_0000_8765_4321, 1'b0, 5'd0);
    do_load(1'b1, 32'h000C, 3'b000, 1, 64'h8765_4321_0000_0001, 64'hFFFF_FFFF_8765_4321, 1'b0, 5'd0);
    do_load(1'b1, 32'h0007, 3'b010, 2, 64'h8765_4321_0000_0001, 64'hFFFF_FFFF_FFFF_FF87, 1'b0, 5'd0);
    do_load(1'b1, 32'h0006, 3'b100, 1, 64'h8765_4321_0000_0001, 64'hFFFF_FFFF_FFFF_8765, 1'b0, 5'd0);
    do_load(1'b1, 32'h0008, 3'b110, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0);
    do_load(1'b1, 32'h000C, 3'b110, 0, 64'h0, 64'h0, 1'b1, 5'd4);
    do_load(1'b1, 32'h000B, 3'b001, 1, 64'h0123_4567_89AB_CDEF, 64'h89, 1'b0, 5'd0);
    do_load(1'b1, 32'h0004, 3'b111, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567, 1'b0, 5'd0);

    // Reset during a bus wait aborts the transaction silently.
    @(negedge clk);
    sel = 1'b0; c_req_valid = 1'b1; c_req_addr = 32'h0100; c_req_op = 3'b000;
    @(negedge clk);
    c_req_valid = 1'b0;
    chk("abort bus_rd_req c1", 64'(a_bus_rd_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    chk("abort bus_rd_req c2", 64'(a_bus_rd_req), 64'd1);
    @(negedge clk);
    reset = 1'b0; c_ack = 1'b1; c_rdata = 64'h1234_5678;
    chk("abort req_ready c3", 64'(a_req_ready), 64'd1);
    chk("abort outputs c3", {a_bus_rd_req, a_bus_addr, a_rsp_valid, a_rsp_exc, a_rsp_exccode, a_busy}, 64'd0);
    chk("abort rsp_data c3", 64'(a_rsp_data), 64'd0);
    @(negedge clk);
    c_ack = 1'b0;
    chk("abort rsp_valid c4", 64'(a_rsp_valid), 64'd0);
    chk("abort bus_rd_req c4", 64'(a_bus_rd_req), 64'd0);

    repeat (3) @(negedge clk);
    chk("d32 scoreboard drained", 64'(q32.size()), 64'd0);
    chk("d64 scoreboard drained", 64'(q64.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_load_unit.md
# w_load_unit

Parametrised, handshaked load-data unit for the memory/writeback boundary of the pipelined CPU. Accepts a load request, checks alignment, issues an aligned read to the data bus, waits for the acknowledge or a timeout, then extracts the addressed byte/half/word/doubleword from the returned beat and zero- or sign-extends it to `DATA_W`. Raises AdEL on misaligned addresses and a data-bus error on timeout. Stalls the pipeline through `busy` while a transaction is outstanding.

## Interface
- `DATA_W`, 32: bus and result width; legal values 32 or 64.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 16: cycles in BUS without ack before a bus error; must be ≥1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_addr`  in  ADDR_W  byte address.
- `req_op`  in  3  000 word sign-ext, 001 lbu, 010 lb, 011 lhu, 100 lh, 101 word zero-ext, 110 full beat (DATA_W=64 only; decodes as 000 when DATA_W=32), 111 decodes as 000.
- `bus_rd_req`  out  1  read request, held until ack or timeout.
- `bus_addr`  out  ADDR_W  `req_addr` with low log2(DATA_W/8) bits cleared.
- `bus_rd_ack`  in  1  read data valid this cycle.
- `bus_rdata`  in  DATA_W  read beat.
- `rsp_valid`  out  1  one-cycle result pulse.
- `rsp_data`  out  DATA_W  extended result; 0 when `rsp_exc`=1.
- `rsp_exc`  out  1  exception flag, qualified by `rsp_valid`.
- `rsp_exccode`  out  5  4 = AdEL, 7 = DBE, 0 otherwise.
- `busy`  out  1  high in BUS or RESP.

## Operation
- OFF = `req_addr[log2(DATA_W/8)-1:0]`, latched with addr and op on accept.
- States: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch request; if misaligned -> RESP with exc; else -> BUS, counter cleared.
- Alignment: bytes always aligned; halfs need A[0]=0; words A[1:0]=0; op 110 A[2:0]=0.
- BUS: `bus_rd_req`=1, `bus_addr` stable. On `bus_rd_ack`: latch extended data, -> RESP. Else counter++; counter reaching TIMEOUT-1 with no ack -> RESP with exccode 7.
- Extraction: byte lane = OFF, half lane = OFF>>1, word lane = OFF>>2 (DATA_W=64). Sign-extend from MSB of extracted field for 000/010/100; zero-extend for 001/011/101; 110 passes beat unchanged.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0.
- `bus_rd_ack` outside BUS ignored. Request fields not sampled outside IDLE.

## Timing
- Reset: state IDLE; `req_ready`=1; `bus_rd_req`, `bus_addr`, `rsp_valid`, `rsp_data`, `rsp_exc`, `rsp_exccode`, `busy`, counter all 0.
- Reset mid-BUS or mid-RESP: transaction aborted; no `rsp_valid`; `bus_rd_req` low next cycle.
- Accept cycle 0; `bus_rd_req` first high cycle 1; ack in cycle k≥1 -> `rsp_valid` in cycle k+1. Minimum aligned latency 2 cycles accept-to-response.
- Misaligned: accept cycle 0 -> `rsp_valid` with exc cycle 1; no bus request ever asserted.
- Timeout: `bus_rd_req` high cycles 1..TIMEOUT; no ack -> `rsp_valid`, exccode 7 in cycle TIMEOUT+1.
- Ack in the same cycle as the final timeout count: ack wins, normal response.
- Back-to-back: next request accepted in the cycle after RESP (throughput one load per ≥3 cycles).
- All outputs registered except `req_ready` and `busy`, decoded from state.

## Test plan
- DATA_W=32, lb addr 0x1003, ack cycle 1 with rdata 0x80FF_1234 -> `rsp_valid` cycle 2, data 0xFFFF_FF80, exc 0.
- DATA_W=32, lhu addr 0x2002, rdata 0x8001_7FFF, ack delayed to cycle 5 -> response cycle 6, data 0x0000_8001; `bus_addr`=0x2000 throughout BUS.
- DATA_W=32, lh addr 0x0001 -> `rsp_valid` cycle 1, exc 1, exccode 4, data 0, `bus_rd_req` never high.
- TIMEOUT=4, word 0x0100, no ack -> `bus_rd_req` cycles 1-4, response cycle 5 exccode 7; repeat with ack in cycle 4 -> normal data.
- DATA_W=64, op 101 addr 0x0C, rdata 0x8765_4321_0000_0001 -> data 0x0000_0000_8765_4321; op 000 same -> 0xFFFF_FFFF_8765_4321.
- Reset asserted in cycle 2 of a BUS wait, ack in cycle 3 -> no `rsp_valid`, all outputs 0, `req_ready`=1 in cycle 3.
